// File: rtl/logical_tile_io_preio_gearbox.sv
// Framed serial gearbox in front of the QL_PREIO pad: start bit + WIDTH data bits, LSB first.
// Define IO_GEARBOX_LOOPBACK_EN to feed the RX deserialiser from the TX line register instead of pad_inpad.
module logical_tile_io_preio_gearbox #(
    parameter int   WIDTH      = 4,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             pad_clk,
    input  logic             pad_reset,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx_busy,
    output logic             pad_outpad,
    input  logic             pad_inpad,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA} tx_state_t;
    typedef enum logic {RX_HUNT, RX_RECV} rx_state_t;

    tx_state_t        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
    logic             pad_out_q, pad_out_d;
    logic             rdy_en_q, rdy_en_d;
    logic             tx_accept;

    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [WIDTH-2:0] rx_sh_q, rx_sh_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic [WIDTH-1:0] rx_word;
    logic             rx_bit;

    // rdy_en_q holds tx_ready low for the first cycle out of reset
    assign tx_ready   = rdy_en_q & ((tx_state_q == TX_IDLE) ||
                                    ((tx_state_q == TX_DATA) && (tx_cnt_q == LAST)));
    assign tx_accept  = tx_valid & tx_ready;
    assign tx_busy    = (tx_state_q != TX_IDLE);
    assign pad_outpad = pad_out_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;

    // pad_out_d is the line value for the coming cycle, so the pad stays a plain register
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_sh_d    = tx_sh_q;
        pad_out_d  = IDLE_LEVEL;
        rdy_en_d   = 1'b1;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_accept) begin
                    tx_state_d = TX_START;
                    tx_sh_d    = tx_data;
                    tx_cnt_d   = '0;
                    pad_out_d  = ~IDLE_LEVEL;
                end
            end
            TX_START: begin
                tx_state_d = TX_DATA;
                tx_cnt_d   = '0;
                pad_out_d  = tx_sh_q[0];
            end
            TX_DATA: begin
                if (tx_cnt_q == LAST) begin
                    tx_cnt_d = '0;
                    if (tx_accept) begin
                        tx_state_d = TX_START;
                        tx_sh_d    = tx_data;
                        pad_out_d  = ~IDLE_LEVEL;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end else begin
                    tx_cnt_d  = tx_cnt_q + CNT_W'(1);
                    tx_sh_d   = tx_sh_q >> 1;
                    pad_out_d = tx_sh_q[1];
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

`ifdef IO_GEARBOX_LOOPBACK_EN
    assign rx_bit = pad_out_q;
`else
    logic sync1_q, sync2_q;

    always_ff @(posedge pad_clk) begin
        if (pad_reset) begin
            sync1_q <= IDLE_LEVEL;
            sync2_q <= IDLE_LEVEL;
        end else begin
            sync1_q <= pad_inpad;
            sync2_q <= sync1_q;
        end
    end

    assign rx_bit = sync2_q;
`endif

    // Only WIDTH-1 bits are stored; the final bit is merged straight into rx_data
    assign rx_word = {rx_bit, rx_sh_q};

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        case (rx_state_q)
            RX_HUNT: begin
                if (rx_bit == ~IDLE_LEVEL) begin
                    rx_state_d = RX_RECV;
                    rx_cnt_d   = '0;
                end
            end
            RX_RECV: begin
                rx_sh_d = rx_word[WIDTH-1:1];
                if (rx_cnt_q == LAST) begin
                    rx_data_d  = rx_word;
                    rx_valid_d = 1'b1;
                    rx_state_d = RX_HUNT;
                    rx_cnt_d   = '0;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            default: rx_state_d = RX_HUNT;
        endcase
    end

    always_ff @(posedge pad_clk) begin
        if (pad_reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_sh_q    <= '0;
            pad_out_q  <= IDLE_LEVEL;
            rdy_en_q   <= 1'b0;
            rx_state_q <= RX_HUNT;
            rx_cnt_q   <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_sh_q    <= tx_sh_d;
            pad_out_q  <= pad_out_d;
            rdy_en_q   <= rdy_en_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

endmodule

// File: tb/tb_logical_tile_io_preio_gearbox.sv
// Directed bench for logical_tile_io_preio_gearbox (WIDTH=4, IDLE_LEVEL=0, synchronised RX path).
// The bench can route pad_outpad back into pad_inpad externally to exercise TX and RX together.
module tb_logical_tile_io_preio_gearbox;

    logic       pad_clk;
    logic       pad_reset;
    logic [3:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;
    logic       pad_outpad;
    logic       pad_inpad;
    logic [3:0] rx_data;
    logic       rx_valid;

    logic lb;
    logic ext_in;
    int   n_checks = 0;
    int   n_errors = 0;
    int   vld_cnt  = 0;

    assign pad_inpad = lb ? pad_outpad : ext_in;

    logical_tile_io_preio_gearbox #(.WIDTH(4), .IDLE_LEVEL(1'b0)) dut (
        .pad_clk    (pad_clk),
        .pad_reset  (pad_reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_busy    (tx_busy),
        .pad_outpad (pad_outpad),
        .pad_inpad  (pad_inpad),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid)
    );

    initial pad_clk = 1'b0;
    always #5 pad_clk = ~pad_clk;

    always @(negedge pad_clk) if (rx_valid) vld_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pad_clk);
        #1;
    endtask

    initial begin
        int c0;
        int busy_cnt;
        int seq[6]   = '{1, 1, 1, 0, 1, 0};
        int frame[5] = '{1, 1, 0, 1, 1};

        pad_reset = 1'b1;
        tx_valid  = 1'b0;
        tx_data   = 4'h0;
        lb        = 1'b1;
        ext_in    = 1'b0;
        tick();
        tick();
        check("rst_pad", pad_outpad, 0);
        check("rst_ready", tx_ready, 0);
        check("rst_busy", tx_busy, 0);
        check("rst_rxv", rx_valid, 0);
        check("rst_rxd", rx_data, 0);
        pad_reset = 1'b0;
        check("ready_at_release", tx_ready, 0);
        tick();
        check("ready_after_release", tx_ready, 1);

        c0 = vld_cnt;
        repeat (10) tick();
        check("idle_pad", pad_outpad, 0);
        check("idle_ready", tx_ready, 1);
        check("idle_busy", tx_busy, 0);
        check("idle_no_rxv", vld_cnt - c0, 0);

        // single frame 4'b1011: start, 1,1,0,1, then idle
        tx_data  = 4'b1011;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("tx1011_pad%0d", i), pad_outpad, seq[i]);
            check($sformatf("tx1011_busy%0d", i), tx_busy, (i < 5) ? 1 : 0);
            check($sformatf("tx1011_ready%0d", i), tx_ready, (i >= 4) ? 1 : 0);
            tick();
        end
        check("lb1011_rxv_n7", rx_valid, 0);
        tick();
        check("lb1011_rxv_n8", rx_valid, 1);
        check("lb1011_rxd", rx_data, 4'hB);
        tick();
        check("lb1011_rxv_n9", rx_valid, 0);

        // back-to-back 4'hA then 4'h5 with tx_valid held high
        tx_data  = 4'hA;
        tx_valid = 1'b1;
        tick();
        tx_data  = 4'h5;
        busy_cnt = 0;
        for (int k = 1; k <= 14; k++) begin
            if (k <= 10) busy_cnt += int'(tx_busy);
            if (k == 4) check("b2b_ready_k4", tx_ready, 0);
            if (k == 5) begin
                check("b2b_ready_k5", tx_ready, 1);
                check("b2b_pad_bit3", pad_outpad, 1);
            end
            if (k == 6) begin
                check("b2b_pad_start2", pad_outpad, 1);
                tx_valid = 1'b0;
            end
            if (k == 8) begin
                check("b2b_rxv1", rx_valid, 1);
                check("b2b_rxd1", rx_data, 4'hA);
            end
            if (k == 11) begin
                check("b2b_busy_end", tx_busy, 0);
                check("b2b_pad_end", pad_outpad, 0);
            end
            if (k == 13) begin
                check("b2b_rxv2", rx_valid, 1);
                check("b2b_rxd2", rx_data, 4'h5);
            end
            tick();
        end
        check("b2b_busy_cycles", busy_cnt, 10);

        // external frame on pad_inpad: start bit then 4'hD LSB first
        lb     = 1'b0;
        ext_in = 1'b0;
        repeat (3) tick();
        c0 = vld_cnt;
        for (int i = 0; i < 5; i++) begin
            ext_in = frame[i][0];
            tick();
        end
        ext_in = 1'b0;
        tick();
        check("ext_rxv_early", rx_valid, 0);
        tick();
        check("ext_rxv", rx_valid, 1);
        check("ext_rxd", rx_data, 4'hD);
        tick();
        check("ext_rxv_after", rx_valid, 0);
        check("ext_rxd_hold", rx_data, 4'hD);
        check("ext_single_pulse", vld_cnt - c0, 1);

        // reset during DATA bit 1
        lb       = 1'b1;
        tx_data  = 4'h6;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tick();
        tick();
        check("mid_busy", tx_busy, 1);
        check("mid_pad_bit1", pad_outpad, 1);
        pad_reset = 1'b1;
        c0 = vld_cnt;
        tick();
        check("mid_rst_pad", pad_outpad, 0);
        check("mid_rst_busy", tx_busy, 0);
        check("mid_rst_rxv", rx_valid, 0);
        check("mid_rst_ready", tx_ready, 0);
        pad_reset = 1'b0;
        tick();
        check("mid_ready_back", tx_ready, 1);
        repeat (8) tick();
        check("mid_no_rxv", vld_cnt - c0, 0);
        check("mid_rxd_clear", rx_data, 0);

        tx_data  = 4'h9;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        repeat (6) tick();
        check("fresh_rxv_n7", rx_valid, 0);
        tick();
        check("fresh_rxv", rx_valid, 1);
        check("fresh_rxd", rx_data, 4'h9);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
